i2c_regbus_arbiter: RTL and testbench
=====================================

# i2c_regbus_arbiter

Shares one register-target bus between two requesters: the I2C frame bridge (port 0) and a local host (port 1). Port 0 issues level-style strobes (`wr_en`/`rd_en`), which stay high for several clocks. The arbiter converts each rising edge into exactly one target transaction and holds read data stable for the bridge's byte serializer. It arbitrates round-robin, drives a ready-handshaked target bus, and aborts stalled accesses with a timeout.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 15: maximum `ACCESS` cycles before abort; legal range 2..255.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `m0_addr` in ADDR_W: bridge address.
- `m0_wr_en` in 1: bridge write strobe (level).
- `m0_rd_en` in 1: bridge read strobe (level).
- `m0_wdata` in DATA_W: bridge write data.
- `m0_rdata` out DATA_W: last port-0 read result, held.
- `m0_err` out 1: sticky; last port-0 access timed out.
- `m0_ovr` out 1: sticky until reset; a port-0 request was dropped while one was pending.
- `m1_req` in 1: host request; held with `m1_we`/`m1_addr`/`m1_wdata` stable until `m1_ack`.
- `m1_we` in 1: host write.
- `m1_addr` in ADDR_W: host address.
- `m1_wdata` in DATA_W: host write data.
- `m1_ack` out 1: one-cycle completion pulse.
- `m1_rdata` out DATA_W: host read result, valid with `m1_ack`.
- `m1_err` out 1: timeout flag, valid with `m1_ack`.
- `t_req` out 1: target request, registered.
- `t_we` out 1: target write, registered.
- `t_addr` out ADDR_W: target address, registered.
- `t_wdata` out DATA_W: target write data, registered.
- `t_ready` in 1: target completion, sampled only while `t_req`=1.
- `t_rdata` in DATA_W: target read data, valid with `t_ready`.

## Operation
- Port-0 capture:
  - At each edge, register the previous values of `m0_wr_en` and `m0_rd_en`.
  - A rise on either strobe sets `pend0` and captures `m0_addr`, `m0_wdata`, and `we0`.
  - Write wins if both strobes rise together.
  - A rise while `pend0`=1 is dropped and sets `m0_ovr`.
  - A new capture clears `m0_err`.
- Port 1 is pending whenever `m1_req`=1 in `IDLE`.
- FSM states are `IDLE`, `ACCESS`, `DONE`.
  - `IDLE` → `ACCESS` when any requester is pending. Load `t_*` from the winner, set `t_req`=1, clear the timeout counter, and record `owner`.
  - Arbitration is round-robin. If both requesters are pending, grant the port other than `last_grant`. `last_grant` resets to 1, so port 0 wins the first tie.
  - `ACCESS` → `DONE` on `t_ready`=1. Set `t_req`=0.
    - Owner 0: `pend0`=0; if a read, `m0_rdata`=`t_rdata`.
    - Owner 1: `m1_ack`=1, `m1_rdata`=`t_rdata` (0 for writes), `m1_err`=0.
  - `ACCESS` → `DONE` when the counter reaches TIMEOUT−1 with no `t_ready`. Set `t_req`=0.
    - Owner 0: `m0_err`=1, `pend0`=0, and reads load `m0_rdata`=32'hDEAD_BEEF.
    - Owner 1: `m1_ack`=1, `m1_err`=1, `m1_rdata`=32'hDEAD_BEEF.
  - `DONE` → `IDLE` unconditionally. Clear `m1_ack`/`m1_err`. This guard cycle stops a host that drops `m1_req` on the edge after `m1_ack` from being double-granted.
- `m0_rdata` holds until the next port-0 read completion; writes never alter it.
- `t_addr`/`t_we`/`t_wdata` hold their values outside `ACCESS`.

## Timing
- Reset values: state=`IDLE`, `t_req`=0, `t_we`=0, `t_addr`=0, `t_wdata`=0, `m0_rdata`=0, `m0_err`=0, `m0_ovr`=0, `m1_ack`=0, `m1_rdata`=0, `m1_err`=0, `pend0`=0, `last_grant`=1, counter=0.
- Port-0 latency:
  - Strobe sampled high (previous low) at edge E: `pend0`=1 after E.
  - `t_req` rises at E+1 if granted.
  - With `t_ready` at edge E+1+k, `m0_rdata` updates at that edge.
- Port-1 latency: `m1_req` sampled at edge E in `IDLE` → `t_req` after E; `m1_ack` high in the cycle after the `t_ready` edge.
- Minimum access is 3 cycles: `IDLE`→`ACCESS`→`DONE`→`IDLE`.
- Timeout: `t_req` is high for exactly TIMEOUT cycles, then drops.
- A port-0 strobe that rises during `ACCESS`/`DONE` is captured normally and served after `DONE`.
- An asynchronous reset mid-access drops `t_req` immediately; no ack is issued afterward.

## Structure
- Package `i2c_regbus_pkg` holds:
  - FSM state encoding.
  - `ABORT_DATA` = 32'hDEAD_BEEF.
  - Default `ADDR_W`/`DATA_W`.
- One sub-module, `i2c_req_capture`: edge detection, `pend0`/`m0_ovr`, and the captured request registers, with a clear input driven by the FSM.

## Test plan
- Port-0 write: `m0_addr`=0x0010, `m0_wdata`=0xA5A5_1234, `m0_wr_en` high for 20 cycles, `t_ready` on the 2nd `ACCESS` cycle → exactly one `t_req` with `t_we`=1 and matching addr/data; no second access.
- Port-0 read: `m0_rd_en` rise, `t_rdata`=0xCAFE_F00D → `m0_rdata`=0xCAFE_F00D and held through later writes.
- Simultaneous `pend0` and `m1_req` after reset → port 0 granted first, port 1 next. Repeat the tie → port 1 first.
- Host read, `t_ready` never asserted, TIMEOUT=15 → `t_req` high 15 cycles; `m1_ack`=1, `m1_err`=1, `m1_rdata`=0xDEAD_BEEF.
- Second `m0_wr_en` rise while the first is still pending → `m0_ovr`=1; only one target write is issued.
- `rst_n` low during `ACCESS` → `t_req`=0 immediately, all outputs at reset values, no `m1_ack`.

Source files
------------

// File: rtl/i2c_regbus_pkg.sv
// Shared types and constants for the I2C / host register-bus arbiter.
package i2c_regbus_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  // Read data returned on an aborted (timed-out) access.
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/i2c_regbus_arbiter_capture.sv
// Port-0 strobe edge detection: turns level strobes into one pending request
// and records overruns when a new edge arrives while one is still pending.
module i2c_req_capture
  import i2c_regbus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wr_en,
  input  logic              m0_rd_en,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              clr,
  output logic              pend0,
  output logic              we0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] wdata0,
  output logic              ovr,
  output logic              cap
);

  logic              wr_prev_q, wr_prev_d;
  logic              rd_prev_q, rd_prev_d;
  logic              pend0_q, pend0_d;
  logic              we0_q, we0_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [DATA_W-1:0] wdata0_q, wdata0_d;
  logic              ovr_q, ovr_d;
  logic              wr_rise, rd_rise;

  always_comb begin
    wr_rise   = m0_wr_en & ~wr_prev_q;
    rd_rise   = m0_rd_en & ~rd_prev_q;
    wr_prev_d = m0_wr_en;
    rd_prev_d = m0_rd_en;
    pend0_d   = pend0_q;
    we0_d     = we0_q;
    addr0_d   = addr0_q;
    wdata0_d  = wdata0_q;
    ovr_d     = ovr_q;
    cap       = (wr_rise | rd_rise) & ~pend0_q;
    // clr only arrives while pend0_q=1, so it never collides with cap.
    if (clr) pend0_d = 1'b0;
    if (cap) begin
      pend0_d  = 1'b1;
      we0_d    = wr_rise;
      addr0_d  = m0_addr;
      wdata0_d = m0_wdata;
    end else if (wr_rise | rd_rise) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      pend0_q   <= 1'b0;
      we0_q     <= 1'b0;
      addr0_q   <= '0;
      wdata0_q  <= '0;
      ovr_q     <= 1'b0;
    end else begin
      wr_prev_q <= wr_prev_d;
      rd_prev_q <= rd_prev_d;
      pend0_q   <= pend0_d;
      we0_q     <= we0_d;
      addr0_q   <= addr0_d;
      wdata0_q  <= wdata0_d;
      ovr_q     <= ovr_d;
    end
  end

  assign pend0  = pend0_q;
  assign we0    = we0_q;
  assign addr0  = addr0_q;
  assign wdata0 = wdata0_q;
  assign ovr    = ovr_q;

endmodule

// File: rtl/i2c_regbus_arbiter.sv
// Round-robin arbiter sharing one ready-handshaked register target between
// the I2C bridge (port 0, level strobes) and a local host (port 1).
module i2c_regbus_arbiter
  import i2c_regbus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wr_en,
  input  logic              m0_rd_en,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  output logic              m0_ovr,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              t_req,
  output logic              t_we,
  output logic [ADDR_W-1:0] t_addr,
  output logic [DATA_W-1:0] t_wdata,
  input  logic              t_ready,
  input  logic [DATA_W-1:0] t_rdata
);

  state_e            state_q, state_d;
  logic              t_req_q, t_req_d;
  logic              t_we_q, t_we_d;
  logic [ADDR_W-1:0] t_addr_q, t_addr_d;
  logic [DATA_W-1:0] t_wdata_q, t_wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic              m0_err_q, m0_err_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m1_err_q, m1_err_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              pend0, we0, cap0, clr0, grant;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;

  i2c_req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cap (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_addr  (m0_addr),
    .m0_wr_en (m0_wr_en),
    .m0_rd_en (m0_rd_en),
    .m0_wdata (m0_wdata),
    .clr      (clr0),
    .pend0    (pend0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .ovr      (m0_ovr),
    .cap      (cap0)
  );

  always_comb begin
    state_d      = state_q;
    t_req_d      = t_req_q;
    t_we_d       = t_we_q;
    t_addr_d     = t_addr_q;
    t_wdata_d    = t_wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m0_err_d     = m0_err_q;
    m1_ack_d     = m1_ack_q;
    m1_rdata_d   = m1_rdata_q;
    m1_err_d     = m1_err_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    clr0         = 1'b0;
    // On a tie, the port that did not win last time goes next.
    grant        = m1_req ? (pend0 ? ~last_grant_q : 1'b1) : 1'b0;
    if (cap0) m0_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend0 || m1_req) begin
          state_d      = ST_ACCESS;
          t_req_d      = 1'b1;
          t_we_d       = grant ? m1_we    : we0;
          t_addr_d     = grant ? m1_addr  : addr0;
          t_wdata_d    = grant ? m1_wdata : wdata0;
          cnt_d        = 8'd0;
          owner_d      = grant;
          last_grant_d = grant;
        end
      end
      ST_ACCESS: begin
        if (t_ready) begin
          state_d = ST_DONE;
          t_req_d = 1'b0;
          if (!owner_q) begin
            clr0 = 1'b1;
            if (!t_we_q) m0_rdata_d = t_rdata;
          end else begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = t_we_q ? '0 : t_rdata;
            m1_err_d   = 1'b0;
          end
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          t_req_d = 1'b0;
          if (!owner_q) begin
            clr0     = 1'b1;
            m0_err_d = 1'b1;
            if (!t_we_q) m0_rdata_d = DATA_W'(ABORT_DATA);
          end else begin
            m1_ack_d   = 1'b1;
            m1_err_d   = 1'b1;
            m1_rdata_d = DATA_W'(ABORT_DATA);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        // Guard cycle: the host sees m1_ack and drops m1_req before IDLE samples it.
        state_d  = ST_IDLE;
        m1_ack_d = 1'b0;
        m1_err_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      t_req_q      <= 1'b0;
      t_we_q       <= 1'b0;
      t_addr_q     <= '0;
      t_wdata_q    <= '0;
      m0_rdata_q   <= '0;
      m0_err_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m1_rdata_q   <= '0;
      m1_err_q     <= 1'b0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      t_req_q      <= t_req_d;
      t_we_q       <= t_we_d;
      t_addr_q     <= t_addr_d;
      t_wdata_q    <= t_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_ack_q     <= m1_ack_d;
      m1_rdata_q   <= m1_rdata_d;
      m1_err_q     <= m1_err_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
    end
  end

  assign t_req    = t_req_q;
  assign t_we     = t_we_q;
  assign t_addr   = t_addr_q;
  assign t_wdata  = t_wdata_q;
  assign m0_rdata = m0_rdata_q;
  assign m0_err   = m0_err_q;
  assign m1_ack   = m1_ack_q;
  assign m1_rdata = m1_rdata_q;
  assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_i2c_regbus_arbiter.sv
// Scoreboard bench: stimulus pushes expected target accesses and host acks,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_i2c_regbus_arbiter;
  localparam int AW = 16, DW = 32, TO = 15;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, t_addr;
  logic          m0_wr_en = 1'b0, m0_rd_en = 1'b0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata, t_wdata;
  logic          m0_err, m0_ovr, m1_req = 1'b0, m1_we = 1'b0, m1_ack, m1_err;
  logic          t_req, t_we, t_ready = 1'b0;
  logic [DW-1:0] t_rdata = '0;

  always #5 clk = ~clk;

  i2c_regbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wr_en(m0_wr_en), .m0_rd_en(m0_rd_en),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_err(m0_err), .m0_ovr(m0_ovr),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .t_req(t_req), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .t_ready(t_ready), .t_rdata(t_rdata)
  );

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
  typedef struct { logic [DW-1:0] rdata; logic err; } ack_t;
  txn_t exp_t[$];
  ack_t exp_a[$];
  txn_t et;
  ack_t ea;

  int total = 0, bad = 0;
  int lat = 2;               // ACCESS cycle on which the target answers; 0 = never
  logic [DW-1:0] rdval = '0;
  int acc_n = 0, req_len = 0, last_len = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor + target model
  always @(negedge clk) begin
    if (t_req && !req_prev) begin
      if (exp_t.size() == 0) chk("t_access_unexpected", {16'h0, t_addr}, 32'hFFFF_FFFF);
      else begin
        et = exp_t.pop_front();
        chk("t_we", t_we, et.we);
        chk("t_addr", t_addr, et.addr);
        if (et.we) chk("t_wdata", t_wdata, et.wdata);
      end
    end
    if (m1_ack) begin
      if (exp_a.size() == 0) chk("m1_ack_unexpected", m1_ack, 0);
      else begin
        ea = exp_a.pop_front();
        chk("m1_rdata", m1_rdata, ea.rdata);
        chk("m1_err", m1_err, ea.err);
      end
    end
    if (t_req) req_len++;
    else if (req_prev) begin last_len = req_len; req_len = 0; end
    req_prev = t_req;
    acc_n    = t_req ? acc_n + 1 : 0;
    t_ready  = t_req && (acc_n == lat);
    t_rdata  = rdval;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_wait();
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (m1_ack) got = 1'b1;
    end
    m1_req = 1'b0;
    chk("host_ack_seen", got, 1);
  endtask

  task automatic push_t(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    exp_t.push_back(t);
  endtask

  task automatic push_a(input logic [DW-1:0] d, input logic e);
    ack_t a;
    a.rdata = d; a.err = e;
    exp_a.push_back(a);
  endtask

  initial begin
    bit seen;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_t_req", t_req, 0);
    chk("rst_t_addr", t_addr, 0);
    chk("rst_t_wdata", t_wdata, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m0_flags", {m0_err, m0_ovr, m1_ack, m1_err}, 0);

    // Port-0 write, strobe held 20 cycles: exactly one access
    push_t(1'b1, 16'h0010, 32'hA5A5_1234);
    m0_addr = 16'h0010; m0_wdata = 32'hA5A5_1234; m0_wr_en = 1'b1;
    cyc(20);
    m0_wr_en = 1'b0;
    cyc(5);
    chk("wr_m0_err", m0_err, 0);
    chk("wr_m0_ovr", m0_ovr, 0);

    // Port-0 read, then a write must not disturb m0_rdata
    rdval = 32'hCAFE_F00D;
    push_t(1'b0, 16'h0020, 32'h0);
    m0_addr = 16'h0020; m0_rd_en = 1'b1;
    cyc(5);
    m0_rd_en = 1'b0;
    cyc(5);
    chk("rd_m0_rdata", m0_rdata, 32'hCAFE_F00D);
    rdval = 32'h0BAD_F00D;
    push_t(1'b1, 16'h0030, 32'h1111_2222);
    m0_addr = 16'h0030; m0_wdata = 32'h1111_2222; m0_wr_en = 1'b1;
    cyc(8);
    m0_wr_en = 1'b0;
    cyc(2);
    chk("rd_hold_after_wr", m0_rdata, 32'hCAFE_F00D);

    // Tie after reset: port 0 first, then port 1
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
    push_t(1'b1, 16'h0040, 32'h44);
    push_t(1'b1, 16'h0050, 32'h55);
    push_a(32'h0, 1'b0);
    m0_addr = 16'h0040; m0_wdata = 32'h44; m0_wr_en = 1'b1;
    cyc(1);
    m1_we = 1'b1; m1_addr = 16'h0050; m1_wdata = 32'h55; m1_req = 1'b1;
    host_wait();
    m0_wr_en = 1'b0;
    cyc(3);

    // Lone port-0 access leaves last_grant=0, so the next tie goes to port 1
    push_t(1'b1, 16'h0041, 32'h45);
    m0_addr = 16'h0041; m0_wdata = 32'h45; m0_wr_en = 1'b1;
    cyc(8);
    m0_wr_en = 1'b0;
    cyc(2);
    rdval = 32'h1234_5678;
    push_t(1'b0, 16'h0051, 32'h0);
    push_t(1'b1, 16'h0042, 32'h46);
    push_a(32'h1234_5678, 1'b0);
    m0_addr = 16'h0042; m0_wdata = 32'h46; m0_wr_en = 1'b1;
    cyc(1);
    m1_we = 1'b0; m1_addr = 16'h0051; m1_req = 1'b1;
    host_wait();
    cyc(8);
    m0_wr_en = 1'b0;
    cyc(2);

    // Host read timeout
    lat = 0;
    push_t(1'b0, 16'h0060, 32'h0);
    push_a(32'hDEAD_BEEF, 1'b1);
    m1_we = 1'b0; m1_addr = 16'h0060; m1_req = 1'b1;
    host_wait();
    cyc(2);
    chk("timeout_t_req_len", last_len, TO);

    // Port-0 read timeout
    push_t(1'b0, 16'h0090, 32'h0);
    m0_addr = 16'h0090; m0_rd_en = 1'b1;
    cyc(25);
    m0_rd_en = 1'b0;
    chk("p0_to_err", m0_err, 1);
    chk("p0_to_rdata", m0_rdata, 32'hDEAD_BEEF);

    // Overrun: second rise while pending is dropped
    lat = 6;
    push_t(1'b1, 16'h0070, 32'h77);
    m0_addr = 16'h0070; m0_wdata = 32'h77; m0_wr_en = 1'b1;
    cyc(2); m0_wr_en = 1'b0;
    cyc(1); m0_wr_en = 1'b1;
    cyc(2); m0_wr_en = 1'b0;
    cyc(10);
    chk("ovr_set", m0_ovr, 1);
    chk("ovr_err_cleared", m0_err, 0);
    chk("ovr_rdata_held", m0_rdata, 32'hDEAD_BEEF);

    // Async reset mid-access
    lat = 0;
    push_t(1'b0, 16'h0080, 32'h0);
    m1_we = 1'b0; m1_addr = 16'h0080; m1_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (t_req) seen = 1'b1;
    end
    chk("rst_mid_access_started", seen, 1);
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_t_req", t_req, 0);
    chk("rst_mid_t_addr", t_addr, 0);
    chk("rst_mid_m0_rdata", m0_rdata, 0);
    chk("rst_mid_m1_rdata", m1_rdata, 0);
    chk("rst_mid_flags", {m0_err, m0_ovr, m1_ack, m1_err}, 0);
    m1_req = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    chk("post_rst_t_req", t_req, 0);

    chk("exp_t_drained", exp_t.size(), 0);
    chk("exp_a_drained", exp_a.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, got stuck want done");
    $fatal(1);
  end

endmodule
